ber_monitor: RTL and testbench
==============================

Name: ber_monitor

Overview:
- Bit-error-rate checker sitting directly downstream of the Viterbi decoder in the tx/rx loopback.
- Receives the source bits fed to the convolutional encoder and the decoded bits from the decoder.
- Discovers decoder latency automatically and then counts compared bits and residual bit errors.
- Loss of alignment is detected, and the block re-acquires alignment on its own.

Parameters:
- MAX_LAT, 64: depth of the reference history. Latencies 0..MAX_LAT-1 are searchable. Power of 2.
- WIN, 32: compared bits per acquisition and monitoring window.
- LOCK_ERR_MAX, 2: maximum errors in a SEARCH window for a candidate latency to be accepted.
- LOSS_ERR_THR, 8: errors in one LOCKED window strictly greater than this value cause loss of lock.
- CNT_W, 16: width of the bit and error counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- ref_bit_i  in  1  source bit presented to the encoder
- ref_valid_i  in  1  ref_bit_i is accepted this cycle
- dec_bit_i  in  1  decoded bit from the decoder
- dec_valid_i  in  1  dec_bit_i is valid this cycle
- clear_i  in  1  synchronous clear of bit_cnt_o and err_cnt_o only
- locked_o  out  1  alignment acquired
- latency_o  out  $clog2(MAX_LAT)  current or candidate latency, in reference bits
- bit_cnt_o  out  CNT_W  bits compared while LOCKED, saturating
- err_cnt_o  out  CNT_W  mismatches while LOCKED, saturating
- lock_lost_o  out  1  one-cycle pulse on the LOCKED->SEARCH transition

Behaviour:
- Reset (rst=0, async):
  - State is SEARCH, latency 0, history cleared, fill count 0.
  - Window bit and error counters are 0.
  - All outputs are 0.
- History:
  - On ref_valid_i, ref_bit_i shifts into hist[0] and older bits move up.
  - The fill count increments, saturating at MAX_LAT.
- Comparison:
  - On dec_valid_i, dec_bit_i is compared with hist[lat], where hist[0] is the most recent reference bit accepted before this cycle.
  - When ref_valid_i and dec_valid_i occur in the same cycle, the comparison uses the pre-shift history.
  - A comparison is qualified only when fill count > lat. Unqualified dec_valid_i is ignored entirely: no counting, no window advance.
- Window:
  - Each qualified comparison increments win_bits.
  - A mismatch also increments win_errs, width $clog2(WIN+1).
  - When win_bits reaches WIN, the window closes in that cycle, the decision below is taken, and both window counters reset to 0.
- SEARCH:
  - At window close with win_errs <= LOCK_ERR_MAX: go to LOCKED; latency unchanged; locked_o=1 from the next cycle.
  - Otherwise: lat increments, wrapping from MAX_LAT-1 to 0; stay in SEARCH.
- LOCKED:
  - Each qualified comparison increments bit_cnt_o; a mismatch also increments err_cnt_o.
  - Both counters saturate at 2^CNT_W-1 and do not wrap.
  - At window close with win_errs > LOSS_ERR_THR:
    - Go to SEARCH with lat+1 (wrapping).
    - locked_o=0 next cycle.
    - lock_lost_o pulses for exactly one cycle.
    - bit_cnt_o and err_cnt_o hold their values.
  - Otherwise stay in LOCKED.
- latency_o reflects lat continuously in both states.
- clear_i:
  - Zeroes bit_cnt_o and err_cnt_o next cycle.
  - Has priority over a simultaneous increment.
  - Does not affect state, latency, history or window counters.
- Outputs are registered, with no combinational path from input to output. Counter updates are visible one cycle after the qualifying dec_valid_i.
- A mid-operation reset returns everything to reset values immediately; no pulse is generated.

Test Plan:
- Clean stream at a fixed delay:
  - Stimulus: PRBS ref bits every cycle; dec = ref delayed by 10 bits; no errors.
  - Required: locked_o=1 with latency_o=10 after at most 11 windows plus fill time; err_cnt_o stays 0; bit_cnt_o increments by 1 per cycle.
- Sparse errors while locked:
  - Stimulus: locked at latency 10; invert 2 of every 32 decoded bits.
  - Required: after 256 further bits, err_cnt_o=16 and bit_cnt_o=256; locked_o stays 1; lock_lost_o never asserts.
- Loss and re-acquire:
  - Stimulus: locked at latency 10; switch the decoder delay to 13.
  - Required: lock_lost_o pulses once within one window; locked_o drops; re-lock at latency_o=13 with counters held across the loss.
- Saturation and clear:
  - Stimulus: CNT_W=4; run 40 locked bits, all inverted after lock.
  - Required: err_cnt_o=15 and bit_cnt_o=15 (saturated); assert clear_i with dec_valid_i in the same cycle -> both counters read 0 next cycle; locked_o unaffected.
- Simultaneous valid and gaps:
  - Stimulus: ref_valid_i and dec_valid_i asserted together on random cycles, around 50% duty, delay 5.
  - Required: lock at latency_o=5; err_cnt_o=0; bit_cnt_o equals the count of dec_valid_i cycles after lock.
- Reset mid-window:
  - Stimulus: assert rst during a LOCKED window.
  - Required: all outputs 0 asynchronously; no lock_lost_o pulse; after release, re-acquire from latency 0.

Source files
------------

// File: rtl/ber_monitor.sv
// rtl/ber_monitor.sv - BER checker behind the Viterbi decoder: latency search, lock tracking, error counting
module ber_monitor #(
  parameter int MAX_LAT      = 64,
  parameter int WIN          = 32,
  parameter int LOCK_ERR_MAX = 2,
  parameter int LOSS_ERR_THR = 8,
  parameter int CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ref_bit_i,
  input  logic                       ref_valid_i,
  input  logic                       dec_bit_i,
  input  logic                       dec_valid_i,
  input  logic                       clear_i,
  output logic                       locked_o,
  output logic [$clog2(MAX_LAT)-1:0] latency_o,
  output logic [CNT_W-1:0]           bit_cnt_o,
  output logic [CNT_W-1:0]           err_cnt_o,
  output logic                       lock_lost_o
);

  localparam int LAT_W  = $clog2(MAX_LAT);
  localparam int FILL_W = LAT_W + 1;
  localparam int WB_W   = $clog2(WIN + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t             state;
  logic [MAX_LAT-1:0] hist;
  logic [FILL_W-1:0]  fill;
  logic [LAT_W-1:0]   lat;
  logic [WB_W-1:0]    win_bits;
  logic [WB_W-1:0]    win_errs;

  logic               qual;
  logic               mis;
  logic               close;
  logic [WB_W-1:0]    bits_nxt;
  logic [WB_W-1:0]    errs_nxt;

  // Compare against pre-shift history so a same-cycle ref bit never aliases into the check.
  always_comb begin
    qual     = dec_valid_i && (fill > {1'b0, lat});
    mis      = dec_bit_i ^ hist[lat];
    bits_nxt = win_bits + 1'b1;
    errs_nxt = win_errs + WB_W'(mis);
    close    = qual && (bits_nxt == WB_W'(WIN));
  end

  assign latency_o = lat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SEARCH;
      hist        <= '0;
      fill        <= '0;
      lat         <= '0;
      win_bits    <= '0;
      win_errs    <= '0;
      locked_o    <= 1'b0;
      bit_cnt_o   <= '0;
      err_cnt_o   <= '0;
      lock_lost_o <= 1'b0;
    end else begin
      lock_lost_o <= 1'b0;

      if (ref_valid_i) begin
        hist <= {hist[MAX_LAT-2:0], ref_bit_i};
        if (fill != FILL_W'(MAX_LAT))
          fill <= fill + 1'b1;
      end

      if (qual) begin
        if (close) begin
          win_bits <= '0;
          win_errs <= '0;
        end else begin
          win_bits <= bits_nxt;
          win_errs <= errs_nxt;
        end

        case (state)
          SEARCH: begin
            if (close) begin
              if (errs_nxt <= WB_W'(LOCK_ERR_MAX)) begin
                state    <= LOCKED;
                locked_o <= 1'b1;
              end else begin
                lat <= lat + 1'b1;
              end
            end
          end
          LOCKED: begin
            if (bit_cnt_o != '1)
              bit_cnt_o <= bit_cnt_o + 1'b1;
            if (mis && err_cnt_o != '1)
              err_cnt_o <= err_cnt_o + 1'b1;
            if (close && errs_nxt > WB_W'(LOSS_ERR_THR)) begin
              state       <= SEARCH;
              locked_o    <= 1'b0;
              lat         <= lat + 1'b1;
              lock_lost_o <= 1'b1;
            end
          end
          default: state <= SEARCH;
        endcase
      end

      // Placed last so a clear wins over a same-cycle increment.
      if (clear_i) begin
        bit_cnt_o <= '0;
        err_cnt_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ber_monitor.sv
// tb/tb_ber_monitor.sv - directed bench for ber_monitor with a queue-based reference model
module tb_ber_monitor;
  localparam int MAX_LAT = 64;
  localparam int WIN     = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ref_bit = 1'b0, ref_valid = 1'b0, dec_bit = 1'b0, dec_valid = 1'b0, clear = 1'b0;
  logic       locked, lost, locked4, lost4;
  logic [5:0] latency, latency4;
  logic [15:0] bit_cnt, err_cnt;
  logic [3:0]  bit_cnt4, err_cnt4;

  always #5 clk = ~clk;

  ber_monitor u_dut (
    .clk(clk), .rst(rst), .ref_bit_i(ref_bit), .ref_valid_i(ref_valid),
    .dec_bit_i(dec_bit), .dec_valid_i(dec_valid), .clear_i(clear),
    .locked_o(locked), .latency_o(latency), .bit_cnt_o(bit_cnt),
    .err_cnt_o(err_cnt), .lock_lost_o(lost)
  );

  ber_monitor #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .ref_bit_i(ref_bit), .ref_valid_i(ref_valid),
    .dec_bit_i(dec_bit), .dec_valid_i(dec_valid), .clear_i(clear),
    .locked_o(locked4), .latency_o(latency4), .bit_cnt_o(bit_cnt4),
    .err_cnt_o(err_cnt4), .lock_lost_o(lost4)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Reference model: list of accepted ref bits (newest first), window tallies, unbounded counts.
  bit mq[$];
  int m_lat, wb, we, raw_b, raw_e;
  bit m_locked, m_lost, m_qual, m_mis;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_lat = 0; wb = 0; we = 0; raw_b = 0; raw_e = 0;
      m_locked = 0; m_lost = 0;
    end else begin
      m_lost = 0;
      m_qual = dec_valid && (mq.size() > m_lat);
      if (m_qual) begin
        m_mis = (dec_bit != mq[m_lat]);
        wb++;
        if (m_mis) we++;
        if (m_locked) begin
          raw_b++;
          if (m_mis) raw_e++;
        end
      end
      if (clear) begin
        raw_b = 0;
        raw_e = 0;
      end
      if (m_qual && wb == WIN) begin
        if (!m_locked) begin
          if (we <= 2) m_locked = 1;
          else m_lat = (m_lat + 1) % MAX_LAT;
        end else if (we > 8) begin
          m_locked = 0;
          m_lat = (m_lat + 1) % MAX_LAT;
          m_lost = 1;
        end
        wb = 0;
        we = 0;
      end
      if (ref_valid) begin
        mq.push_front(ref_bit);
        if (mq.size() > MAX_LAT) void'(mq.pop_back());
      end
    end
  end

  int lost_seen = 0;
  always @(negedge clk) begin
    if (lost) lost_seen++;
    check("locked", locked, m_locked);
    check("latency", latency, m_lat);
    check("lock_lost", lost, m_lost);
    check("bit_cnt", bit_cnt, sat(raw_b, 65535));
    check("err_cnt", err_cnt, sat(raw_e, 65535));
    check("bit_cnt4", bit_cnt4, sat(raw_b, 15));
    check("err_cnt4", err_cnt4, sat(raw_e, 15));
  end

  // Stimulus: refs holds every ref bit sent; the decoder output is that stream delayed by 'delay' bits.
  bit refs[$];
  int delay = 10;

  task automatic step(input bit rv, input bit dv, input bit inv, input bit clr);
    ref_valid = rv;
    ref_bit   = 1'($urandom_range(0, 1));
    dec_valid = dv && (refs.size() > delay);
    dec_bit   = dec_valid ? (refs[refs.size() - 1 - delay] ^ inv) : 1'b0;
    clear     = clr;
    if (rv) refs.push_back(ref_bit);
    @(negedge clk);
    #1;
  endtask

  int cyc, nvalid, lost_before;
  bit v;

  initial begin
    @(negedge clk);
    #1;
    check("rst_locked", locked, 0);
    check("rst_latency", latency, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_lock_lost", lost, 0);
    rst = 1'b1;

    // Clean stream at delay 10
    delay = 10;
    cyc = 0;
    while (!locked && cyc < 1000) begin step(1, 1, 0, 0); cyc++; end
    check("t1_lock_timeout", (cyc < 1000), 1);
    check("t1_latency", latency, 10);
    check("t1_bit_cnt_at_lock", bit_cnt, 0);
    repeat (5) step(1, 1, 0, 0);
    check("t1_bit_cnt_5", bit_cnt, 5);
    check("t1_err_cnt", err_cnt, 0);

    // Sparse errors: 2 of every 32 bits inverted
    step(0, 0, 0, 1);
    for (int k = 0; k < 256; k++) step(1, 1, (k % 32) < 2, 0);
    check("t2_bit_cnt", bit_cnt, 256);
    check("t2_err_cnt", err_cnt, 16);
    check("t2_bit_cnt4_sat", bit_cnt4, 15);
    check("t2_err_cnt4_sat", err_cnt4, 15);
    check("t2_locked", locked, 1);
    check("t2_no_loss", lost_seen, 0);

    // Decoder delay jumps to 13
    delay = 13;
    cyc = 0;
    while (lost_seen == 0 && cyc < 64) begin step(1, 1, 0, 0); cyc++; end
    check("t3_loss_timeout", (cyc < 64), 1);
    check("t3_locked_dropped", locked, 0);
    cyc = 0;
    while (!locked && cyc < 1000) begin step(1, 1, 0, 0); cyc++; end
    check("t3_relock_timeout", (cyc < 1000), 1);
    check("t3_latency", latency, 13);
    check("t3_single_pulse", lost_seen, 1);

    // Saturation and clear
    step(0, 0, 0, 1);
    for (int k = 0; k < 40; k++) step(1, 1, 1, 0);
    check("t4_bit_cnt", bit_cnt, 32);
    check("t4_err_cnt", err_cnt, 32);
    check("t4_bit_cnt4", bit_cnt4, 15);
    check("t4_err_cnt4", err_cnt4, 15);
    check("t4_locked", locked, 0);
    check("t4_latency", latency, 14);
    check("t4_pulses", lost_seen, 2);
    step(1, 1, 0, 1);
    check("t4_clr_bit_cnt", bit_cnt, 0);
    check("t4_clr_err_cnt", err_cnt, 0);
    check("t4_clr_bit_cnt4", bit_cnt4, 0);
    check("t4_clr_err_cnt4", err_cnt4, 0);
    check("t4_clr_locked", locked, 0);
    check("t4_clr_latency", latency, 14);

    // Simultaneous valids with gaps, delay 5
    rst = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b1;
    delay = 5;
    cyc = 0;
    while (!locked && cyc < 3000) begin
      v = 1'($urandom_range(0, 1));
      step(v, v, 0, 0);
      cyc++;
    end
    check("t5_lock_timeout", (cyc < 3000), 1);
    check("t5_latency", latency, 5);
    nvalid = 0;
    for (int k = 0; k < 100; k++) begin
      v = 1'($urandom_range(0, 1));
      step(v, v, 0, 0);
      if (dec_valid) nvalid++;
    end
    check("t5_bit_cnt", bit_cnt, nvalid);
    check("t5_err_cnt", err_cnt, 0);
    check("t5_locked", locked, 1);

    // Reset in the middle of a locked window
    repeat (10) step(1, 1, 0, 0);
    lost_before = lost_seen;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_locked", locked, 0);
    check("t6_latency", latency, 0);
    check("t6_bit_cnt", bit_cnt, 0);
    check("t6_err_cnt", err_cnt, 0);
    check("t6_lock_lost", lost, 0);
    step(0, 0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 0);
    check("t6_rel_latency", latency, 0);
    check("t6_rel_locked", locked, 0);
    cyc = 0;
    while (!locked && cyc < 1000) begin step(1, 1, 0, 0); cyc++; end
    check("t6_relock_timeout", (cyc < 1000), 1);
    check("t6_relock_latency", latency, 5);
    check("t6_no_pulse", lost_seen, lost_before);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
